// File: rtl/div_rate_sequencer_pkg.sv
// Shared types and defaults for the divider rate sequencer.
// Tap limits here must match clock_divider.
package div_rate_sequencer_pkg;

  localparam int SEL_W = 5;
  localparam int TMR_W = 22;
  localparam int CNT_W = 4;

  localparam int DEF_SEL_MIN = 0;
  localparam int DEF_SEL_MAX = 20;
  localparam int DEF_SEL_RST = 9;
  localparam int DEF_SETTLE  = 2;
  localparam int DEF_TIMEOUT = (1 << TMR_W) - 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_FALL,
    ST_APPLY,
    ST_SETTLE
  } state_t;

  function automatic logic [SEL_W-1:0] clamp_sel(
    input logic [SEL_W-1:0] v,
    input logic [SEL_W-1:0] lo,
    input logic [SEL_W-1:0] hi
  );
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/div_rate_sequencer_edge_detect_fall.sv
// Falling-edge detector for the divided clock.
// One history flop; fall is high while d is low after a high sample.
module edge_detect_fall (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic fall
);

  logic d_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) d_q <= 1'b0;
    else        d_q <= d;
  end

  assign fall = d_q & ~d;

endmodule

// File: rtl/div_rate_sequencer.sv
// Divider tap-select sequencer: arbitrates button/config rate requests
// and walks sel one tap per div_clk falling edge toward the target.
module div_rate_sequencer
  import div_rate_sequencer_pkg::*;
#(
  parameter int SEL_MIN = DEF_SEL_MIN,
  parameter int SEL_MAX = DEF_SEL_MAX,
  parameter int SEL_RST = DEF_SEL_RST,
  parameter int SETTLE  = DEF_SETTLE,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step_up,
  input  logic             step_dn,
  input  logic             cfg_req,
  input  logic [SEL_W-1:0] cfg_sel,
  output logic             cfg_ack,
  input  logic             div_clk,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic             at_min,
  output logic             at_max
);

  localparam logic [SEL_W-1:0] MIN_L = SEL_W'(SEL_MIN);
  localparam logic [SEL_W-1:0] MAX_L = SEL_W'(SEL_MAX);
  localparam logic [SEL_W-1:0] RST_L = SEL_W'(SEL_RST);
  localparam logic [TMR_W-1:0] TMO_L = TMR_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] SET_L = CNT_W'(SETTLE - 1);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] tgt_q, tgt_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ack_q, ack_d;
  logic             busy_q, busy_d;
  logic             fall;
  logic             take_cfg;
  logic             inc;
  logic             dec;

  edge_detect_fall u_fall (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (div_clk),
    .fall  (fall)
  );

  // Config wins over steps; the ack gap blocks back-to-back loads.
  assign take_cfg = cfg_req & ~ack_q;
  assign inc = ~take_cfg & step_up & ~step_dn
             & (tgt_q != MAX_L);
  assign dec = ~take_cfg & step_dn & ~step_up
             & (tgt_q != MIN_L);

  always_comb begin
    tgt_d = tgt_q;
    ack_d = 1'b0;
    unique case (1'b1)
      take_cfg: begin
        tgt_d = clamp_sel(cfg_sel, MIN_L, MAX_L);
        ack_d = 1'b1;
      end
      inc:     tgt_d = tgt_q + SEL_W'(1);
      dec:     tgt_d = tgt_q - SEL_W'(1);
      default: tgt_d = tgt_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    tmr_d   = tmr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (sel_q != tgt_q) begin
          state_d = ST_WAIT_FALL;
          tmr_d   = '0;
        end
      end
      ST_WAIT_FALL: begin
        if (fall || tmr_q == TMO_L) begin
          state_d = ST_APPLY;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      ST_APPLY: begin
        // Direction taken from the live target so a reversal never overshoots.
        if (tgt_q > sel_q) begin
          sel_d = sel_q + SEL_W'(1);
        end else if (tgt_q < sel_q) begin
          sel_d = sel_q - SEL_W'(1);
        end
        state_d = ST_SETTLE;
        cnt_d   = '0;
      end
      ST_SETTLE: begin
        if (cnt_q == SET_L) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy_d = (state_d != ST_IDLE) | (sel_d != tgt_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= RST_L;
      tgt_q   <= RST_L;
      tmr_q   <= '0;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      tgt_q   <= tgt_d;
      tmr_q   <= tmr_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  assign sel     = sel_q;
  assign busy    = busy_q;
  assign cfg_ack = ack_q;
  assign at_min  = (tgt_q == MIN_L);
  assign at_max  = (tgt_q == MAX_L);

endmodule

// File: tb/tb_div_rate_sequencer.sv
// Randomized bench for div_rate_sequencer against a target/ack model
// plus edge-timing rules for every sel movement.
module tb_div_rate_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       step_up = 1'b0;
  logic       step_dn = 1'b0;
  logic       cfg_req = 1'b0;
  logic [4:0] cfg_sel = 5'd0;
  logic       div_clk = 1'b0;
  logic       cfg_ack;
  logic [4:0] sel;
  logic       busy;
  logic       at_min;
  logic       at_max;

  div_rate_sequencer #(.TIMEOUT(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .step_up (step_up),
    .step_dn (step_dn),
    .cfg_req (cfg_req),
    .cfg_sel (cfg_sel),
    .cfg_ack (cfg_ack),
    .div_clk (div_clk),
    .sel     (sel),
    .busy    (busy),
    .at_min  (at_min),
    .at_max  (at_max)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  int m_tgt = 9;
  bit m_ack = 1'b0;
  int cyc = 16;
  bit dh[16];
  int th[16];
  int prev_sel = 9;
  bit allow_force = 1'b0;
  int nchg = 0;
  int last_chg = -1;

  bit dc_run = 1'b0;
  bit dc_rand = 1'b0;
  int dc_half = 4;
  int dc_cnt = 0;

  task automatic chk(string tag, int got, int exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic bit fall_at(int c);
    return dh[c % 16] == 1'b0 && dh[(c - 1) % 16] == 1'b1;
  endfunction

  task automatic model_reset();
    m_tgt = 9;
    m_ack = 1'b0;
    cyc = 16;
    prev_sel = 9;
    for (int i = 0; i < 16; i++) begin
      dh[i] = 1'b0;
      th[i] = 9;
    end
  endtask

  task automatic tick();
    int nt;
    bit na;
    if (dc_run) begin
      dc_cnt++;
      if (dc_cnt >= dc_half) begin
        div_clk = ~div_clk;
        dc_cnt = 0;
        if (dc_rand) dc_half = $urandom_range(1, 4);
      end
    end
    nt = m_tgt;
    na = 1'b0;
    if (cfg_req && !m_ack) begin
      nt = (int'(cfg_sel) > 20) ? 20 : int'(cfg_sel);
      na = 1'b1;
    end else if (step_up && !step_dn && m_tgt < 20) begin
      nt = m_tgt + 1;
    end else if (step_dn && !step_up && m_tgt > 0) begin
      nt = m_tgt - 1;
    end
    @(posedge clk);
    cyc++;
    dh[cyc % 16] = div_clk;
    th[cyc % 16] = nt;
    m_tgt = nt;
    m_ack = na;
    @(negedge clk);
    chk("cfg_ack", cfg_ack, m_ack);
    chk("at_min", at_min, m_tgt == 0);
    chk("at_max", at_max, m_tgt == 20);
    if (int'(sel) != prev_sel) begin
      int p;
      int dir;
      p = cyc - 1;
      dir = (th[p % 16] > prev_sel) ? 1 : -1;
      chk("sel_step", sel, prev_sel + dir);
      if (!allow_force) chk("sel_on_fall", fall_at(p), 1);
      nchg++;
      last_chg = cyc;
    end
    if (int'(sel) != m_tgt) chk("busy_walk", busy, 1);
    prev_sel = sel;
  endtask

  task automatic do_cfg(int v);
    int n;
    cfg_sel = 5'(v);
    cfg_req = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!cfg_ack && n < 4);
    cfg_req = 1'b0;
    chk("cfg_ack_seen", cfg_ack, 1);
  endtask

  task automatic settle(string tag, int exp, int bound);
    int n;
    n = 0;
    while (!(int'(sel) == m_tgt && !busy) && n < bound) begin
      tick();
      n++;
    end
    chk({tag, "_sel"}, sel, exp);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int ts;
    int ff;
    int n;
    model_reset();

    // reset release, idle
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) tick();
    chk("t1_sel", sel, 9);
    chk("t1_busy", busy, 0);
    chk("t1_chg", nchg, 0);

    // single step, square wave period 8
    dc_run = 1'b1;
    dc_rand = 1'b0;
    dc_half = 4;
    for (int i = 0; i < 11; i++) tick();
    step_up = 1'b1;
    tick();
    step_up = 1'b0;
    ts = cyc;
    ff = -1;
    n = 0;
    while (int'(sel) == 9 && n < 40) begin
      tick();
      n++;
      if (ff < 0 && cyc >= ts + 2 && fall_at(cyc)) ff = cyc;
    end
    chk("t2_sel", sel, 10);
    chk("t2_lat", last_chg, ff + 1);
    tick();
    chk("t2_busy_hold", busy, 1);
    tick();
    chk("t2_busy_drop", busy, 0);

    // config walk down, then clamp
    nchg = 0;
    do_cfg(3);
    settle("t3_walk", 3, 200);
    chk("t3_steps", nchg, 7);
    do_cfg(31);
    chk("t3_at_max", at_max, 1);
    settle("t3_clamp", 20, 300);

    // simultaneous requests and saturation
    step_up = 1'b1;
    step_dn = 1'b1;
    tick();
    step_up = 1'b0;
    step_dn = 1'b0;
    settle("t4_both", 20, 20);
    cfg_sel = 5'd5;
    cfg_req = 1'b1;
    step_dn = 1'b1;
    tick();
    cfg_req = 1'b0;
    step_dn = 1'b0;
    chk("t4_ack", cfg_ack, 1);
    settle("t4_cfgwin", 5, 300);
    do_cfg(0);
    settle("t4_zero", 0, 100);
    step_dn = 1'b1;
    tick();
    step_dn = 1'b0;
    chk("t4_at_min", at_min, 1);
    settle("t4_sat", 0, 20);

    // watchdog forced apply with div_clk stuck low
    dc_run = 1'b0;
    div_clk = 1'b0;
    tick();
    tick();
    allow_force = 1'b1;
    step_up = 1'b1;
    tick();
    step_up = 1'b0;
    ts = cyc;
    n = 0;
    while (int'(sel) == 0 && n < 40) begin
      tick();
      n++;
    end
    chk("t5_sel", sel, 1);
    chk("t5_lat", last_chg - ts, 19);
    settle("t5_done", 1, 10);
    allow_force = 1'b0;

    // reset mid-walk
    dc_run = 1'b1;
    dc_half = 4;
    do_cfg(9);
    settle("t6_pre", 9, 200);
    do_cfg(3);
    n = 0;
    while (int'(sel) != 6 && n < 100) begin
      tick();
      n++;
    end
    chk("t6_mid", sel, 6);
    rst_n = 1'b0;
    #1;
    chk("t6_sel", sel, 9);
    chk("t6_busy", busy, 0);
    chk("t6_ack", cfg_ack, 0);
    chk("t6_at_max", at_max, 0);
    @(negedge clk);
    @(negedge clk);
    model_reset();
    dc_run = 1'b0;
    div_clk = 1'b0;
    dc_cnt = 0;
    rst_n = 1'b1;
    dc_run = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("t6_post", sel, 9);
    chk("t6_post_busy", busy, 0);

    // randomized traffic
    dc_rand = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if (cfg_req && cfg_ack) begin
        if ($urandom_range(0, 3) != 0) cfg_req = 1'b0;
      end else if (!cfg_req && $urandom_range(0, 29) == 0) begin
        cfg_req = 1'b1;
        cfg_sel = 5'($urandom);
      end
      step_up = ($urandom_range(0, 7) == 0);
      step_dn = ($urandom_range(0, 7) == 0);
      tick();
    end
    cfg_req = 1'b0;
    step_up = 1'b0;
    step_dn = 1'b0;
    tick();
    settle("rand_end", m_tgt, 400);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
